// File: rtl/clock_mode_ctrl_if.sv
// Button/time inputs and mode/setup outputs between the board-level environment
// and the clock mode controller.
`timescale 1ns/1ps
interface clock_mode_ctrl_if;
  logic [3:0]  button;
  logic [23:0] time_now;
  logic [1:0]  rezhim;
  logic [1:0]  field_sel;
  logic [23:0] setup_data;
  logic        load_time;

  modport master (
    output button, time_now,
    input  rezhim, field_sel, setup_data, load_time
  );

  modport slave (
    input  button, time_now,
    output rezhim, field_sel, setup_data, load_time
  );
endinterface

// File: rtl/clock_mode_ctrl.sv
// Clock front-end: synchronizes and debounces the four buttons, sequences the
// display/setup mode, edits the setup time field by field and strobes the commit.
`timescale 1ns/1ps
module clock_mode_ctrl #(
  parameter int DEB_CYCLES     = 16,
  parameter int TIMEOUT_CYCLES = 1000000
) (
  input  logic              clock,
  input  logic              reset,
  clock_mode_ctrl_if.slave  bus
);

  localparam int DEB_W = $clog2(DEB_CYCLES + 1);
  localparam int TO_W  = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [DEB_W-1:0] DEB_LAST = DEB_W'(DEB_CYCLES - 1);
  localparam logic [TO_W-1:0]  TO_LAST  = TO_W'(TIMEOUT_CYCLES - 1);

  typedef enum logic [1:0] {
    S_TIME  = 2'd0,
    S_ALARM = 2'd1,
    S_STOPW = 2'd2,
    S_SETUP = 2'd3
  } state_t;

  localparam logic [1:0] F_NONE = 2'd0;
  localparam logic [1:0] F_SEC  = 2'd1;
  localparam logic [1:0] F_MIN  = 2'd2;
  localparam logic [1:0] F_HOUR = 2'd3;

  logic [3:0]       sync1, sync2, deb, press;
  logic [DEB_W-1:0] deb_cnt [4];

  // NOTE: every register, including each debounce counter in the array, is
  // cleared by the async reset so a button held across reset cannot fire early.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      sync1 <= '0;
      sync2 <= '0;
      deb   <= '0;
      press <= '0;
      for (int i = 0; i < 4; i++) deb_cnt[i] <= '0;
    end else begin
      // NOTE: non-blocking assignments so sync1 -> sync2 forms a true 2-FF chain.
      sync1 <= bus.button;
      sync2 <= sync1;
      for (int i = 0; i < 4; i++) begin
        press[i] <= 1'b0;
        if (sync2[i] == deb[i]) begin
          deb_cnt[i] <= '0;
        end else if (deb_cnt[i] == DEB_LAST) begin
          deb_cnt[i] <= '0;
          deb[i]     <= sync2[i];
          press[i]   <= sync2[i];
        end else begin
          deb_cnt[i] <= deb_cnt[i] + 1'b1;
        end
      end
    end
  end

  function automatic logic [7:0] wrap_inc(input logic [7:0] v, input logic [7:0] max_v);
    return (v >= max_v) ? 8'd0 : v + 8'd1;
  endfunction

  state_t            state, state_nx;
  logic [1:0]        field, field_nx;
  logic [23:0]       data, data_nx;
  logic              load, load_nx;
  logic [TO_W-1:0]   to_cnt, to_nx;
  logic              p_cancel, p_next, p_inc, p_mode, any_press;

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state  <= S_TIME;
      field  <= F_NONE;
      data   <= '0;
      load   <= 1'b0;
      to_cnt <= '0;
    end else begin
      state  <= state_nx;
      field  <= field_nx;
      data   <= data_nx;
      load   <= load_nx;
      to_cnt <= to_nx;
    end
  end

  always_comb begin
    // NOTE: defaults first so every path assigns every signal; no latches.
    state_nx  = state;
    field_nx  = field;
    data_nx   = data;
    load_nx   = 1'b0;
    to_nx     = '0;
    any_press = |press;
    p_cancel  = press[3];
    p_next    = press[2] & ~press[3];
    p_inc     = press[1] & ~(|press[3:2]);
    p_mode    = press[0] & ~(|press[3:1]);

    case (state)
      S_SETUP: begin
        to_nx = any_press ? '0 : to_cnt + 1'b1;
        // Inactivity expiry only when no pulse competes in the same cycle.
        if (p_cancel || (!any_press && to_cnt == TO_LAST)) begin
          state_nx = S_TIME;
          field_nx = F_NONE;
          to_nx    = '0;
        end else if (p_next) begin
          if (field == F_HOUR) begin
            load_nx  = 1'b1;
            state_nx = S_TIME;
            field_nx = F_NONE;
          end else begin
            field_nx = field + 2'd1;
          end
        end else if (p_inc) begin
          case (field)
            F_SEC:   data_nx[7:0]   = wrap_inc(data[7:0],   8'd59);
            F_MIN:   data_nx[15:8]  = wrap_inc(data[15:8],  8'd59);
            F_HOUR:  data_nx[23:16] = wrap_inc(data[23:16], 8'd23);
            default: data_nx        = data;
          endcase
        end
      end
      S_TIME:  if (p_mode) state_nx = S_ALARM;
      S_ALARM: if (p_mode) state_nx = S_STOPW;
      S_STOPW: begin
        if (p_mode) begin
          state_nx = S_SETUP;
          data_nx  = bus.time_now;
          field_nx = F_SEC;
        end
      end
      default: state_nx = S_TIME;
    endcase
  end

  assign bus.rezhim     = state;
  assign bus.field_sel  = field;
  assign bus.setup_data = data;
  assign bus.load_time  = load;

endmodule

// File: tb/tb_clock_mode_ctrl.sv
// Directed bench for clock_mode_ctrl: debounce, mode stepping, field editing,
// commit strobe, cancel priority, inactivity timeout and async reset.
`timescale 1ns/1ps
module tb_clock_mode_ctrl;

  logic clock = 1'b0;
  logic reset = 1'b0;

  clock_mode_ctrl_if bus ();
  clock_mode_ctrl_if bus_to ();

  clock_mode_ctrl #(.DEB_CYCLES(16), .TIMEOUT_CYCLES(1000)) dut (
    .clock (clock),
    .reset (reset),
    .bus   (bus)
  );

  clock_mode_ctrl #(.DEB_CYCLES(16), .TIMEOUT_CYCLES(50)) dut_to (
    .clock (clock),
    .reset (reset),
    .bus   (bus_to)
  );

  always #5 clock = ~clock;

  int errors = 0;
  int checks = 0;

  int          load_cnt = 0;
  logic [23:0] ld_data  = '0;
  logic [1:0]  ld_rez   = '0;
  logic [1:0]  ld_field = '0;
  int          to_setup = 0;
  int          to_load  = 0;

  always @(negedge clock) begin
    if (bus.load_time === 1'b1) begin
      load_cnt++;
      ld_data  = bus.setup_data;
      ld_rez   = bus.rezhim;
      ld_field = bus.field_sel;
    end
    if (bus_to.rezhim === 2'd3)    to_setup++;
    if (bus_to.load_time === 1'b1) to_load++;
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic step(input int n);
    repeat (n) @(negedge clock);
  endtask

  // Raise the buttons long enough for sync + debounce + FSM, then release.
  task automatic press(input bit sel, input logic [3:0] m);
    if (sel) bus_to.button = m; else bus.button = m;
    step(24);
    if (sel) bus_to.button = '0; else bus.button = '0;
    step(24);
  endtask

  task automatic do_reset();
    @(negedge clock);
    reset = 1'b0;
    step(2);
    reset = 1'b1;
    step(2);
  endtask

  task automatic enter_setup(input logic [23:0] t);
    bus.time_now = t;
    repeat (3) press(1'b0, 4'b0001);
  endtask

  initial begin
    bus.button    = '0;
    bus.time_now  = '0;
    bus_to.button   = '0;
    bus_to.time_now = 24'h0A0B0C;
    step(3);
    check("rst_rezhim", 32'(bus.rezhim), 32'd0);
    check("rst_field",  32'(bus.field_sel), 32'd0);
    check("rst_data",   32'(bus.setup_data), 32'd0);
    check("rst_load",   32'(bus.load_time), 32'd0);
    reset = 1'b1;
    step(2);

    // Short glitch, then a long hold: one step only
    bus.button = 4'b0001;
    step(3);
    bus.button = '0;
    step(30);
    check("glitch_ignored", 32'(bus.rezhim), 32'd0);
    bus.button = 4'b0001;
    step(100);
    check("hold_once", 32'(bus.rezhim), 32'd1);
    bus.button = '0;
    step(30);
    check("release_no_pulse", 32'(bus.rezhim), 32'd1);
    press(1'b0, 4'b0010);
    check("inc_ignored_mode1", 32'(bus.rezhim), 32'd1);
    press(1'b0, 4'b1000);
    check("cancel_ignored_mode1", 32'(bus.rezhim), 32'd1);
    check("field_none_mode1", 32'(bus.field_sel), 32'd0);

    // Mode stepping into SETUP
    do_reset();
    bus.time_now = 24'h0A3B07;
    press(1'b0, 4'b0001);
    check("mode_1", 32'(bus.rezhim), 32'd1);
    press(1'b0, 4'b0001);
    check("mode_2", 32'(bus.rezhim), 32'd2);
    press(1'b0, 4'b0001);
    check("mode_3", 32'(bus.rezhim), 32'd3);
    check("entry_field", 32'(bus.field_sel), 32'd1);
    check("entry_data", 32'(bus.setup_data), 32'h0A3B07);
    press(1'b0, 4'b0001);
    check("mode_ignored_setup", 32'(bus.rezhim), 32'd3);
    bus.time_now = 24'h123456;
    press(1'b0, 4'b1000);
    check("cancel_rezhim", 32'(bus.rezhim), 32'd0);
    check("cancel_field", 32'(bus.field_sel), 32'd0);
    check("data_held", 32'(bus.setup_data), 32'h0A3B07);

    // Field editing with wrap
    enter_setup(24'h172C3A);
    check("edit_entry", 32'(bus.setup_data), 32'h172C3A);
    press(1'b0, 4'b0010);
    check("sec_59", 32'(bus.setup_data), 32'h172C3B);
    press(1'b0, 4'b0010);
    check("sec_wrap", 32'(bus.setup_data), 32'h172C00);
    press(1'b0, 4'b0010);
    check("sec_1", 32'(bus.setup_data), 32'h172C01);
    press(1'b0, 4'b0100);
    check("field_min", 32'(bus.field_sel), 32'd2);
    press(1'b0, 4'b0100);
    check("field_hour", 32'(bus.field_sel), 32'd3);
    press(1'b0, 4'b0010);
    check("hour_wrap", 32'(bus.setup_data), 32'h002C01);
    check("still_setup", 32'(bus.rezhim), 32'd3);
    press(1'b0, 4'b1000);
    check("no_load_yet", 32'(load_cnt), 32'd0);

    // Commit strobe
    enter_setup(24'h172D05);
    press(1'b0, 4'b0100);
    press(1'b0, 4'b0100);
    check("commit_field3", 32'(bus.field_sel), 32'd3);
    press(1'b0, 4'b0100);
    check("load_once", 32'(load_cnt), 32'd1);
    check("load_data", 32'(ld_data), 32'h172D05);
    check("load_rezhim", 32'(ld_rez), 32'd0);
    check("load_field", 32'(ld_field), 32'd0);
    check("load_low_after", 32'(bus.load_time), 32'd0);
    check("commit_rezhim", 32'(bus.rezhim), 32'd0);

    // Simultaneous INC + CANCEL
    enter_setup(24'h010203);
    press(1'b0, 4'b1010);
    check("cancel_wins_rezhim", 32'(bus.rezhim), 32'd0);
    check("cancel_wins_data", 32'(bus.setup_data), 32'h010203);
    check("cancel_no_load", 32'(load_cnt), 32'd1);

    // Inactivity timeout on the short-timeout instance
    repeat (3) press(1'b1, 4'b0001);
    step(60);
    check("timeout_cycles", 32'(to_setup), 32'd50);
    check("timeout_rezhim", 32'(bus_to.rezhim), 32'd0);
    check("timeout_field", 32'(bus_to.field_sel), 32'd0);
    check("timeout_no_load", 32'(to_load), 32'd0);
    check("timeout_data_held", 32'(bus_to.setup_data), 32'h0A0B0C);

    // Asynchronous reset mid-SETUP
    enter_setup(24'h111111);
    check("pre_reset_setup", 32'(bus.rezhim), 32'd3);
    @(negedge clock);
    reset = 1'b0;
    #1;
    check("async_rezhim", 32'(bus.rezhim), 32'd0);
    check("async_field", 32'(bus.field_sel), 32'd0);
    check("async_data", 32'(bus.setup_data), 32'd0);
    check("async_load", 32'(bus.load_time), 32'd0);
    step(2);
    reset = 1'b1;
    step(4);
    check("reset_no_load", 32'(load_cnt), 32'd1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
